mp_ff_array: RTL

//   Parametrised multi-port flip-flop array with NUM_RD read and NUM_WR write ports, byte-masked writes,

---
 rtl/mp_ff_array_if.sv | 21 ++
 rtl/mp_ff_array.sv | 80 ++++++++
 2 files changed

// File: rtl/mp_ff_array_if.sv
// mp_ff_array_if: read/write port bundle of the multi-port flip-flop array
interface mp_ff_array_if #(
  parameter int S_INDEX = 4,
  parameter int WIDTH   = 32,
  parameter int GRAN    = 8,
  parameter int NUM_RD  = 2,
  parameter int NUM_WR  = 2
);
  localparam int NUM_BYTES = WIDTH / GRAN;
  logic [NUM_RD-1:0]           rcsb;
  logic [NUM_RD*S_INDEX-1:0]   raddr;
  logic [NUM_RD*WIDTH-1:0]     rdata;
  logic [NUM_RD-1:0]           rvalid;
  logic [NUM_WR-1:0]           wcsb;
  logic [NUM_WR*S_INDEX-1:0]   waddr;
  logic [NUM_WR*NUM_BYTES-1:0] wmask;
  logic [NUM_WR*WIDTH-1:0]     wdata;
  logic                        flush;
  modport master (output rcsb, raddr, wcsb, waddr, wmask, wdata, flush, input rdata, rvalid);
  modport slave  (input rcsb, raddr, wcsb, waddr, wmask, wdata, flush, output rdata, rvalid);
endinterface

// File: rtl/mp_ff_array.sv
// mp_ff_array: multi-port byte-masked flip-flop array with valid bits, flush and write-to-read bypass
module mp_ff_array #(
  parameter int S_INDEX = 4,
  parameter int WIDTH   = 32,
  parameter int GRAN    = 8,
  parameter int NUM_RD  = 2,
  parameter int NUM_WR  = 2,
  parameter int BYPASS  = 1
) (
  input logic          clk0,
  input logic          rst0_n,
  mp_ff_array_if.slave bus
);
  localparam int NUM_SETS  = 2 ** S_INDEX;
  localparam int NUM_BYTES = WIDTH / GRAN;
  logic [NUM_RD-1:0]    r_rlive;
  logic [S_INDEX-1:0]   r_raddr [NUM_RD];
  logic [NUM_WR-1:0]    r_wcsb;
  logic [S_INDEX-1:0]   r_waddr [NUM_WR];
  logic [NUM_BYTES-1:0] r_wmask [NUM_WR];
  logic [WIDTH-1:0]     r_wdata [NUM_WR];
  logic [WIDTH-1:0]     r_mem [NUM_SETS];
  logic [WIDTH-1:0]     w_mem [NUM_SETS];
  logic [NUM_SETS-1:0]  r_valid;
  logic [NUM_SETS-1:0]  w_valid;
  logic [NUM_SETS-1:0]  w_wr_hit;
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      r_rlive <= '0;
      r_wcsb  <= '1;
      for (int i = 0; i < NUM_RD; i++) r_raddr[i] <= '0;
      for (int j = 0; j < NUM_WR; j++) begin
        r_waddr[j] <= '0;
        r_wmask[j] <= '0;
        r_wdata[j] <= '0;
      end
    end else begin
      r_rlive <= r_rlive | ~bus.rcsb;
      r_wcsb  <= bus.wcsb;
      for (int i = 0; i < NUM_RD; i++)
        if (!bus.rcsb[i]) r_raddr[i] <= bus.raddr[i*S_INDEX +: S_INDEX];
      for (int j = 0; j < NUM_WR; j++)
        if (!bus.wcsb[j]) begin
          r_waddr[j] <= bus.waddr[j*S_INDEX +: S_INDEX];
          r_wmask[j] <= bus.wmask[j*NUM_BYTES +: NUM_BYTES];
          r_wdata[j] <= bus.wdata[j*WIDTH +: WIDTH];
        end
    end
  end
  // ascending port order lets the highest-index port win each contested slice
  always_comb begin
    w_mem    = r_mem;
    w_wr_hit = '0;
    for (int j = 0; j < NUM_WR; j++)
      if (!r_wcsb[j]) begin
        w_wr_hit[r_waddr[j]] = 1'b1;
        for (int b = 0; b < NUM_BYTES; b++)
          if (r_wmask[j][b]) w_mem[r_waddr[j]][b*GRAN +: GRAN] = r_wdata[j][b*GRAN +: GRAN];
      end
  end
  assign w_valid = (bus.flush ? '0 : r_valid) | w_wr_hit;
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      r_valid <= '0;
      for (int s = 0; s < NUM_SETS; s++) r_mem[s] <= '0;
    end else begin
      r_valid <= w_valid;
      r_mem   <= w_mem;
    end
  end
  always_comb begin
    bus.rdata  = '0;
    bus.rvalid = '0;
    for (int i = 0; i < NUM_RD; i++)
      if (r_rlive[i]) begin
        bus.rdata[i*WIDTH +: WIDTH] = BYPASS != 0 ? w_mem[r_raddr[i]] : r_mem[r_raddr[i]];
        bus.rvalid[i] = r_valid[r_raddr[i]] | (BYPASS != 0 && w_wr_hit[r_raddr[i]]);
      end
  end
endmodule
